// File: rtl/qsys_serial_pkg.sv
// qsys_serial_pkg: shared state encoding, frame length and timeout pattern for the Avalon-to-serial bridge.
//   state_t          : bridge FSM states
//   TIMEOUT_PATTERN  : readdata returned by a timed-out read (slice to DATA_W)
//   frame_len()      : serial frame length {rw, byteenable, address, data}
package qsys_serial_pkg;
   typedef enum logic [2:0] {IDLE, SHIFT_OUT, WAIT_RDY, SHIFT_IN, DONE} state_t;
   localparam logic [63:0] TIMEOUT_PATTERN = '1;
   function automatic int frame_len(input int addr_w, input int data_w);
      return 1 + data_w / 8 + addr_w + data_w;
   endfunction
endpackage

// File: rtl/qsys_serial_shifter.sv
// qsys_serial_shifter: sclk generator, bit counter and parallel-load MSB-first shift register.
//   csi_MCLK_clk, rsi_MRST_reset : clock, asynchronous active-high reset
//   load, din                    : start a run from din (MSB goes out first)
//   nbits                        : bits in the current run, held by the caller
//   sdi                          : serial input, sampled on the edge where sclk rises
//   sclk, sdo                    : serial clock (idle low) and current MSB
//   done                         : one-cycle pulse on the last cycle of the run
//   q                            : low QW bits of the shift register after the pending shift
module qsys_serial_shifter #(
   parameter int W       = 45,
   parameter int QW      = 32,
   parameter int CLK_DIV = 1
) (
   input  logic                   csi_MCLK_clk,
   input  logic                   rsi_MRST_reset,
   input  logic                   load,
   input  logic [W-1:0]           din,
   input  logic [$clog2(W+1)-1:0] nbits,
   input  logic                   sdi,
   output logic                   sclk,
   output logic                   sdo,
   output logic                   done,
   output logic [QW-1:0]          q
);
   localparam int CW = $clog2(2 * CLK_DIV) < 1 ? 1 : $clog2(2 * CLK_DIV);
   localparam int BW = $clog2(W + 1);
   logic [W-1:0]  sr, nxt;
   logic [CW-1:0] cnt;
   logic [BW-1:0] bits;
   logic          run, smp, rise, bit_end;
   assign rise    = run && cnt == CW'(CLK_DIV - 1);
   assign bit_end = run && cnt == CW'(2 * CLK_DIV - 1);
   assign done    = bit_end && bits == nbits - 1'b1;
   // sdi is held in smp from the sclk rise and enters the register at bit end, so sdo only moves while sclk is low
   assign nxt     = {sr[W-2:0], smp};
   assign q       = nxt[QW-1:0];
   assign sdo     = sr[W-1];
   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset)
      if (rsi_MRST_reset) begin
         sr   <= '0;
         cnt  <= '0;
         bits <= '0;
         run  <= 1'b0;
         smp  <= 1'b0;
         sclk <= 1'b0;
      end else if (load) begin
         sr   <= din;
         cnt  <= '0;
         bits <= '0;
         run  <= 1'b1;
         sclk <= 1'b0;
      end else if (run) begin
         cnt <= bit_end ? '0 : cnt + 1'b1;
         if (rise) begin
            sclk <= 1'b1;
            smp  <= sdi;
         end
         if (bit_end) begin
            sclk <= 1'b0;
            sr   <= nxt;
            bits <= bits + 1'b1;
            run  <= !done;
         end
      end
endmodule

// File: rtl/qsys_serial_bridge.sv
// qsys_serial_bridge: Avalon-MM slave that turns each read/write into a framed serial transaction.
//   rsi_MRST_reset, csi_MCLK_clk : asynchronous active-high reset, clock
//   avs_ctrl_*                   : Avalon-MM slave (word address, byte enables, waitrequest)
//   sclk, sle, sdo               : serial clock, outbound frame enable, serial data out (MSB first)
//   sdi, srdy                    : serial data in (MSB first), asynchronous remote ready
//   err_timeout                  : sticky flag set when srdy fails to arrive within TIMEOUT cycles
module qsys_serial_bridge
   import qsys_serial_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int CLK_DIV = 1,
   parameter int TIMEOUT = 1024
) (
   input  logic                rsi_MRST_reset,
   input  logic                csi_MCLK_clk,
   input  logic [ADDR_W-1:0]   avs_ctrl_address,
   input  logic [DATA_W-1:0]   avs_ctrl_writedata,
   input  logic [DATA_W/8-1:0] avs_ctrl_byteenable,
   input  logic                avs_ctrl_write,
   input  logic                avs_ctrl_read,
   output logic [DATA_W-1:0]   avs_ctrl_readdata,
   output logic                avs_ctrl_waitrequest,
   output logic                sclk,
   output logic                sle,
   output logic                sdo,
   input  logic                sdi,
   input  logic                srdy,
   output logic                err_timeout
);
   localparam int F  = frame_len(ADDR_W, DATA_W);
   localparam int BW = $clog2(F + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   state_t            state, nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [TW-1:0]     tcnt;
   logic [F-1:0]      din;
   logic [BW-1:0]     nbits;
   logic [DATA_W-1:0] q;
   logic              pend_wr, srdy_m, srdy_s, load, done, tmo, sh_sdo;
   // the read frame carries a zero data field; the SHIFT_IN run loads all zeros so sdo stays low
   assign din   = state == IDLE ? {avs_ctrl_write, avs_ctrl_byteenable, avs_ctrl_address,
                                   avs_ctrl_write ? avs_ctrl_writedata : {DATA_W{1'b0}}} : '0;
   assign nbits = BW'(state == SHIFT_IN ? DATA_W : F);
   assign tmo   = tcnt == TW'(TIMEOUT - 1);
   assign sle   = state == SHIFT_OUT;
   assign sdo   = sh_sdo && sle;
   assign avs_ctrl_waitrequest = (avs_ctrl_read || avs_ctrl_write) && state != DONE;
   qsys_serial_shifter #(.W(F), .QW(DATA_W), .CLK_DIV(CLK_DIV)) u_shifter (
      .csi_MCLK_clk  (csi_MCLK_clk),
      .rsi_MRST_reset(rsi_MRST_reset),
      .load          (load),
      .din           (din),
      .nbits         (nbits),
      .sdi           (sdi),
      .sclk          (sclk),
      .sdo           (sh_sdo),
      .done          (done),
      .q             (q)
   );
   always_comb begin
      nxt  = state;
      load = 1'b0;
      case (state)
         IDLE: if (avs_ctrl_write || avs_ctrl_read) begin
            nxt  = SHIFT_OUT;
            load = 1'b1;
         end
         SHIFT_OUT: nxt = done ? WAIT_RDY : state;
         // srdy beats a simultaneous timeout
         WAIT_RDY: if (srdy_s) begin
            nxt  = pend_wr ? DONE : SHIFT_IN;
            load = !pend_wr;
         end else if (tmo) nxt = DONE;
         SHIFT_IN: nxt = done ? DONE : state;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset)
      if (rsi_MRST_reset) begin
         state             <= IDLE;
         srdy_m            <= 1'b0;
         srdy_s            <= 1'b0;
         tcnt              <= '0;
         pend_wr           <= 1'b0;
         addr_q            <= '0;
         avs_ctrl_readdata <= '0;
         err_timeout       <= 1'b0;
      end else begin
         state  <= nxt;
         srdy_m <= srdy;
         srdy_s <= srdy_m;
         tcnt   <= state == WAIT_RDY ? tcnt + 1'b1 : '0;
         if (state == IDLE && load) begin
            pend_wr <= avs_ctrl_write;
            addr_q  <= avs_ctrl_address;
         end
         if (state == SHIFT_IN && done) avs_ctrl_readdata <= q;
         if (state == WAIT_RDY && !srdy_s && tmo) begin
            avs_ctrl_readdata <= TIMEOUT_PATTERN[DATA_W-1:0];
            err_timeout       <= 1'b1;
         end
         // an acknowledged write to the all-ones address clears the sticky flag
         if (state == WAIT_RDY && srdy_s && pend_wr && &addr_q) err_timeout <= 1'b0;
      end
endmodule
